// File: rtl/isqrt_pkg.sv
// Shared helpers for the pipelined integer square root: latency query,
// per-stage mask constant and a plain-arithmetic reference.
package isqrt_pkg;

  // Pipeline depth in cycles; one result bit is produced per stage.
  function automatic int isqrt_latency(int n);
    return n / 2;
  endfunction

  // Trial-bit constant for stage i: 1 << (n-2-2i), kept 64 bits wide
  // so callers cast it to their own radicand width.
  function automatic logic [63:0] stage_mask(int n, int i);
    return 64'(1) << (n - 2 - 2 * i);
  endfunction

  // floor(sqrt(v)) for radicands up to 64 bits, built MSB-first by
  // trying each result bit and keeping it while the square still fits.
  function automatic longint unsigned isqrt_ref(longint unsigned v);
    longint unsigned k;
    longint unsigned t;
    k = 0;
    for (int b = 31; b >= 0; b--) begin
      t = k | (64'(1) << b);
      if (t * t <= v) k = t;
    end
    return k;
  endfunction

endpackage

// File: rtl/isqrt_stage.sv
// One restoring square-root step: folds the trial bit m into the partial
// root r and subtracts it from the remainder x when it fits.
module isqrt_stage #(
  parameter int           n = 32,
  parameter logic [n-1:0] m = '0
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] r,
  output logic [n-1:0] x_next,
  output logic [n-1:0] r_next
);

  logic [n-1:0] b;

  // Compare remainder against (root | trial bit); on success keep the bit.
  always_comb begin
    b      = r | m;
    x_next = x;
    r_next = r >> 1;
    if (x >= b) begin
      x_next = x - b;
      r_next = (r >> 1) | m;
    end
  end

endmodule

// File: rtl/isqrt_pipe_with_valid.sv
// Fully pipelined floor(sqrt(in_data)) with a per-stage valid bit.
// Fixed latency of n/2 cycles; data registers only move on valid
// transfers so bubbles never disturb in-flight values and out_data holds
// the last result between valid outputs.
module isqrt_pipe_with_valid
  import isqrt_pkg::*;
#(
  parameter int n = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_vld,
  input  logic [n-1:0]   in_data,
  output logic           out_vld,
  output logic [n/2-1:0] out_data
);

  localparam int LAT = isqrt_latency(n);

  if ((n % 2) != 0 || n < 4) begin : g_bad_width
    $error("isqrt_pipe_with_valid: n must be even and >= 4 (got %0d)", n);
  end

  logic [LAT-1:0] vld_reg;
  logic [LAT-1:0] load;
  logic [n-1:0]   x_reg  [LAT];
  logic [n-1:0]   r_reg  [LAT];
  logic [n-1:0]   x_cur  [LAT];
  logic [n-1:0]   r_cur  [LAT];
  logic [n-1:0]   x_next [LAT];
  logic [n-1:0]   r_next [LAT];

  // Stage i loads when the transfer feeding it is valid.
  assign load = {vld_reg[LAT-2:0], in_vld};

  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign x_cur[gi] = in_data;
      assign r_cur[gi] = '0;
    end else begin : g_rest
      assign x_cur[gi] = x_reg[gi-1];
      assign r_cur[gi] = r_reg[gi-1];
    end

    isqrt_stage #(
      .n (n),
      .m (n'(stage_mask(n, gi)))
    ) u_stage (
      .x      (x_cur[gi]),
      .r      (r_cur[gi]),
      .x_next (x_next[gi]),
      .r_next (r_next[gi])
    );
  end

  // Valid chain: a plain shift register, so any in_vld pattern reappears
  // LAT cycles later unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_reg <= '0;
    end else begin
      vld_reg <= {vld_reg[LAT-2:0], in_vld};
    end
  end

  // Gated stage data registers: hold on bubbles, load on valid transfers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        x_reg[i] <= '0;
        r_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LAT; i++) begin
        if (load[i]) begin
          x_reg[i] <= x_next[i];
          r_reg[i] <= r_next[i];
        end
      end
    end
  end

  assign out_vld  = vld_reg[LAT-1];
  assign out_data = r_reg[LAT-1][n/2-1:0];

endmodule

// File: tb/tb_isqrt_pipe_with_valid.sv
// Bench for isqrt_pipe_with_valid: one n=32 instance for the directed and
// streaming cases, plus n=4, 8 and 16 instances for the width sweep. Each
// instance has a scoreboard of expected results tagged with the cycle on
// which out_vld must appear.
module tb_isqrt_pipe_with_valid;
  import isqrt_pkg::*;

  localparam int NI = 4;
  localparam longint TIME_LIMIT = 2_000_000;

  function automatic int width_of(int k);
    case (k)
      0:       return 32;
      1:       return 4;
      2:       return 8;
      default: return 16;
    endcase
  endfunction

  typedef struct {
    longint unsigned val;
    longint unsigned due;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            in_vld_arr  [NI];
  logic [31:0]     in_data_arr [NI];
  longint unsigned cyc;
  int              checks;
  int              failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference floor(sqrt(v)) by binary search on k*k <= v (v < 2^32).
  function automatic longint unsigned model_sqrt(longint unsigned v);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  task automatic check_eq(string tag, longint unsigned got, longint unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int NW = width_of(gi);
    localparam int LW = NW / 2;
    localparam longint unsigned MASK = (64'(1) << NW) - 1;

    logic          out_vld;
    logic [LW-1:0] out_data;
    exp_t          q[$];
    longint unsigned last_out;

    isqrt_pipe_with_valid #(.n(NW)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (in_vld_arr[gi]),
      .in_data  (in_data_arr[gi][NW-1:0]),
      .out_vld  (out_vld),
      .out_data (out_data)
    );

    // Scoreboard: check outputs, then queue this cycle's input if valid.
    always @(negedge clk) begin
      if (!rst) begin
        q.delete();
        last_out = 0;
        check_eq($sformatf("n%0d_rst_vld", NW), out_vld, 0);
        check_eq($sformatf("n%0d_rst_data", NW), out_data, 0);
      end else begin
        if (q.size() > 0 && q[0].due == cyc) begin
          check_eq($sformatf("n%0d_out_vld", NW), out_vld, 1);
          check_eq($sformatf("n%0d_out_data", NW), out_data, q[0].val);
          $display("txn n=%0d cycle=%0d out_vld=%0d out_data=%0h expected=%0h",
                   NW, cyc, out_vld, out_data, q[0].val);
          last_out = q[0].val;
          void'(q.pop_front());
        end else begin
          check_eq($sformatf("n%0d_idle_vld", NW), out_vld, 0);
          check_eq($sformatf("n%0d_hold_data", NW), out_data, last_out);
        end
        if (in_vld_arr[gi]) begin
          q.push_back('{model_sqrt(longint'(in_data_arr[gi]) & MASK), cyc + LW});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int k, logic v, logic [31:0] d);
    in_vld_arr[k]  = v;
    in_data_arr[k] = d;
    step();
  endtask

  task automatic idle(int k, int cnt);
    for (int i = 0; i < cnt; i++) drive(k, 1'b0, $urandom());
  endtask

  initial begin
    #(TIME_LIMIT);
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dirs [5];
    logic        pat_v [7];
    logic [31:0] pat_d [7];
    logic [31:0] rv;

    cyc      = 0;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_vld_arr[k]  = 1'b0;
      in_data_arr[k] = '0;
    end

    // Reset held, then idle with no valid inputs.
    repeat (3) step();
    rst = 1'b1;
    idle(0, 20);

    check_eq("pkg_latency32", isqrt_latency(32), 16);
    check_eq("pkg_latency8", isqrt_latency(8), 4);

    // Isolated single transfers including both range ends.
    dirs = '{32'd0, 32'd1, 32'd15, 32'd16, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, dirs[i]);
      idle(0, 20);
    end

    // Back-to-back random stream, plus squares and square-minus-one.
    for (int i = 0; i < 100; i++) begin
      if (i < 10) begin
        rv = 32'($urandom_range(1, 65535));
        rv = (i % 2 == 0) ? rv * rv : rv * rv - 1;
      end else begin
        rv = $urandom();
      end
      if (i % 10 == 0) check_eq("pkg_ref", isqrt_ref(longint'(rv)), model_sqrt(longint'(rv)));
      drive(0, 1'b1, rv);
    end
    idle(0, 20);

    // Bubble pattern; bubble data is garbage and must never load.
    pat_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    pat_d = '{32'd9, 32'd0, 32'd0, 32'd25, 32'd26, 32'd0, 32'd1000000};
    for (int i = 0; i < 7; i++) begin
      drive(0, pat_v[i], pat_v[i] ? pat_d[i] : $urandom());
    end
    idle(0, 20);

    // Reset mid-flight drops everything; only the 49 comes out.
    for (int i = 0; i < 5; i++) drive(0, 1'b1, $urandom());
    idle(0, 3);
    rst = 1'b0;
    idle(0, 2);
    rst = 1'b1;
    drive(0, 1'b1, 32'd49);
    idle(0, 20);

    // Width sweep: exhaustive for n=4 and n=8.
    for (int v = 0; v < 16; v++) drive(1, 1'b1, 32'(v));
    idle(1, 6);
    for (int v = 0; v < 256; v++) begin
      drive(2, 1'b1, 32'(v));
      if ($urandom_range(0, 7) == 0) drive(2, 1'b0, $urandom());
    end
    idle(2, 8);

    // n=16: ends of range then random traffic with random bubbles.
    drive(3, 1'b1, 32'd0);
    drive(3, 1'b1, 32'd65535);
    drive(3, 1'b1, 32'd65025);
    drive(3, 1'b1, 32'd65024);
    for (int i = 0; i < 10000; i++) begin
      drive(3, $urandom_range(0, 3) != 0, $urandom());
    end
    idle(3, 12);

    check_eq("drain_n32", g_dut[0].q.size(), 0);
    check_eq("drain_n4",  g_dut[1].q.size(), 0);
    check_eq("drain_n8",  g_dut[2].q.size(), 0);
    check_eq("drain_n16", g_dut[3].q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
